sync_fifo_ram: RTL
==================

SYNC_FIFO_RAM -- requirements
Module: sync_fifo_ram

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, meaning data word width in bits (>=1).
REQ-002 The block SHALL have parameter DEPTH, default 16, meaning storage words (>=2, power of two not required).
REQ-003 The block SHALL have parameter AF_LEVEL, default DEPTH-2, meaning Count at or above which AlmostFull asserts (1..DEPTH).
REQ-004 The block SHALL have parameter AE_LEVEL, default 2, meaning Count at or below which AlmostEmpty asserts (0..DEPTH-1).
REQ-005 The block SHALL have the port Clock, input, 1 bit: single clock, all state updates on rising edge.
REQ-006 The block SHALL have the port Reset, input, 1 bit: asynchronous, active-high reset.
REQ-007 The block SHALL have the port WE, input, 1 bit: write request.
REQ-008 The block SHALL have the port Data, input, WIDTH bits: write data.
REQ-009 The block SHALL have the port RE, input, 1 bit: read request.
REQ-010 The block SHALL have the port ClearErr, input, 1 bit: clears sticky error flags.
REQ-011 The block SHALL have the port Q, output, WIDTH bits: registered read data.
REQ-012 The block SHALL have the port Count, output, $clog2(DEPTH+1) bits: words held.
REQ-013 The block SHALL have the ports Full, Empty, AlmostFull and AlmostEmpty, output, 1 bit each: status flags.
REQ-014 The block SHALL have the ports Overflow and Underflow, output, 1 bit each: sticky error flags.

Function
REQ-015 The block SHALL store words in an inferred WIDTH x DEPTH array with separate write and read pointers, each width $clog2(DEPTH).
REQ-016 The block SHALL wrap each pointer from DEPTH-1 to 0 on increment, including for non-power-of-two DEPTH.
REQ-017 The block SHALL accept a write when WE=1 and either Full=0 or (Full=1 with an accepted read the same cycle).
REQ-018 The block SHALL accept a read when RE=1 and Empty=0; a read on Empty is never accepted, even with a simultaneous WE (no write-to-read bypass).
REQ-019 On an accepted write, the block SHALL store Data at the write pointer and advance the write pointer.
REQ-020 On an accepted read, the block SHALL load Q with the word at the read pointer on the same edge (1-cycle latency from RE) and advance the read pointer.
REQ-021 The block SHALL hold Q when no read is accepted.
REQ-022 The block SHALL update Count as +1 for a write only, -1 for a read only, and unchanged for both or neither.
REQ-023 The block SHALL decode Full=(Count==DEPTH), Empty=(Count==0), AlmostFull=(Count>=AF_LEVEL), AlmostEmpty=(Count<=AE_LEVEL) from registered state only, with no combinational path from WE/RE.
REQ-024 The block SHALL set Overflow on any cycle with WE=1 and the write not accepted; that write SHALL be dropped, leaving pointers and Count unchanged.
REQ-025 The block SHALL set Underflow on any cycle with RE=1 and Empty=1, leaving Q and the read pointer unchanged.
REQ-026 ClearErr=1 SHALL clear Overflow and Underflow on the next edge, except that a new error event in the same cycle sets its flag (set wins).
REQ-027 The block SHALL preserve word order exactly (first in, first out) across any number of pointer wraps.

Reset
REQ-028 While Reset=1, the block SHALL immediately force the pointers to 0, Count to 0, Q to 0, Empty to 1, Full to 0, AlmostEmpty to 1, AlmostFull to 0, and Overflow and Underflow to 0.
REQ-029 A reset asserted mid-operation SHALL discard all held words, and no stale word SHALL be readable afterwards.
REQ-030 The block SHALL NOT clear storage array contents on reset.
REQ-031 After Reset deasserts, the first rising edge SHALL process WE/RE normally.

Verification (WIDTH=8, DEPTH=5, AF_LEVEL=4, AE_LEVEL=1)
REQ-032 After reset, write 0x11,0x22,0x33,0x44,0x55 on consecutive cycles -> Count 1..5; AlmostEmpty drops at Count=2; AlmostFull rises at Count=4; Full rises at Count=5.
REQ-033 From full, assert RE for 5 cycles -> Q=0x11..0x55, each one cycle after RE; Empty=1 after the last read; Underflow=0.
REQ-034 Hold WE=RE=1 for 12 cycles at Count=2 with incrementing data -> Count stays 2; output order matches input order across pointer wrap 4->0.
REQ-035 When Full, WE+RE -> Count=5, the new word is retained, and Overflow=0; when Full, WE alone -> Overflow=1, Count=5, the word is dropped; then ClearErr -> Overflow=0.
REQ-036 When Empty, RE -> Underflow=1 and Q unchanged; when Empty, WE+RE -> Count=1 and Underflow=1.
REQ-037 At Count=3, pulse Reset between edges -> immediately Count=0, Empty=1, Q=0; then write 0xA5 and read -> Q=0xA5.

Source files
------------

// File: rtl/sync_fifo_ram.sv
// Single-clock FIFO over an inferred RAM with registered read data and sticky overflow/underflow flags.
// Q loads one cycle after an accepted RE; writes on Full (without a read) and reads on Empty are dropped.
module sync_fifo_ram #(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 16,
    parameter int AF_LEVEL = DEPTH - 2,
    parameter int AE_LEVEL = 2
) (
    input  logic                         Clock,
    input  logic                         Reset,
    input  logic                         WE,
    input  logic [WIDTH-1:0]             Data,
    input  logic                         RE,
    input  logic                         ClearErr,
    output logic [WIDTH-1:0]             Q,
    output logic [$clog2(DEPTH+1)-1:0]   Count,
    output logic                         Full,
    output logic                         Empty,
    output logic                         AlmostFull,
    output logic                         AlmostEmpty,
    output logic                         Overflow,
    output logic                         Underflow
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             wr_ok;
    logic             rd_ok;

    // Status flags decode only from the registered Count.
    assign Full        = (Count == CW'(DEPTH));
    assign Empty       = (Count == '0);
    assign AlmostFull  = (Count >= CW'(AF_LEVEL));
    assign AlmostEmpty = (Count <= CW'(AE_LEVEL));

    // A full FIFO still takes a write when a read frees a slot on the same edge.
    assign rd_ok = RE && !Empty;
    assign wr_ok = WE && (!Full || rd_ok);

    function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Storage is left untouched by reset; only pointers and Count forget it.
    always_ff @(posedge Clock) begin
        if (wr_ok) begin
            mem[wr_ptr] <= Data;
        end
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            Count  <= '0;
            Q      <= '0;
        end else begin
            if (wr_ok) begin
                wr_ptr <= next_ptr(wr_ptr);
            end
            if (rd_ok) begin
                rd_ptr <= next_ptr(rd_ptr);
                Q      <= mem[rd_ptr];
            end
            if (wr_ok && !rd_ok) begin
                Count <= Count + 1'b1;
            end else if (rd_ok && !wr_ok) begin
                Count <= Count - 1'b1;
            end
        end
    end

    // A new error in the same cycle as ClearErr keeps its flag set.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            Overflow  <= 1'b0;
            Underflow <= 1'b0;
        end else begin
            if (WE && !wr_ok) begin
                Overflow <= 1'b1;
            end else if (ClearErr) begin
                Overflow <= 1'b0;
            end
            if (RE && Empty) begin
                Underflow <= 1'b1;
            end else if (ClearErr) begin
                Underflow <= 1'b0;
            end
        end
    end

endmodule
